// File: rtl/hms_timekeeper_pkg.sv
// rtl/hms_timekeeper_pkg.sv - shared encodings, field widths and limits for the timekeeper
package hms_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [1:0] MODE_CLOCK = 2'd0;
    localparam logic [1:0] MODE_SETUP = 2'd1;
    localparam logic [1:0] MODE_ALARM = 2'd2;

    localparam logic [1:0] POS_SEC  = 2'd0;
    localparam logic [1:0] POS_MIN  = 2'd1;
    localparam logic [1:0] POS_HOUR = 2'd2;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } hms_t;

endpackage

// File: rtl/hms_timekeeper_if.sv
// rtl/hms_timekeeper_if.sv - button pulses in, time/alarm/display state out
interface hms_if;
    import hms_pkg::*;

    logic              i_mode_pulse;
    logic              i_pos_pulse;
    logic              i_inc_pulse;
    logic              i_dec_pulse;
    logic              i_alarm_en;
    logic              i_alarm_clr;
    logic [SEC_W-1:0]  o_sec;
    logic [MIN_W-1:0]  o_min;
    logic [HOUR_W-1:0] o_hour;
    logic [MIN_W-1:0]  o_alarm_min;
    logic [HOUR_W-1:0] o_alarm_hour;
    logic [1:0]        o_mode;
    logic [1:0]        o_position;
    logic              o_blink;
    logic              o_alarm;
    logic              o_day_wrap;

    modport master (
        output i_mode_pulse, i_pos_pulse, i_inc_pulse, i_dec_pulse, i_alarm_en, i_alarm_clr,
        input  o_sec, o_min, o_hour, o_alarm_min, o_alarm_hour, o_mode, o_position,
               o_blink, o_alarm, o_day_wrap
    );

    modport slave (
        input  i_mode_pulse, i_pos_pulse, i_inc_pulse, i_dec_pulse, i_alarm_en, i_alarm_clr,
        output o_sec, o_min, o_hour, o_alarm_min, o_alarm_hour, o_mode, o_position,
               o_blink, o_alarm, o_day_wrap
    );

endinterface

// File: rtl/hms_timekeeper_wrap_cnt.sv
// rtl/hms_timekeeper_wrap_cnt.sv - modulo MAX+1 up/down field counter with carry chain
module wrap_cnt #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             cin,
    output logic [WIDTH-1:0] count,
    output logic             cout
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);

    logic up;

    // A carry-in behaves exactly like an increment key press.
    assign up   = inc | cin;
    assign cout = cin && (count == TOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (up && !dec) begin
            count <= (count == TOP) ? '0 : count + 1'b1;
        end else if (dec && !up) begin
            count <= (count == '0) ? TOP : count - 1'b1;
        end
    end

endmodule

// File: rtl/hms_timekeeper.sv
// rtl/hms_timekeeper.sv - hour:min:sec clock with setup/alarm edit modes and timed alarm
module hms_timekeeper
    import hms_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int HOUR_MAX  = 23,
    parameter int ALARM_LEN = 60
) (
    input  logic clk,
    input  logic rst_n,
    hms_if.slave bus
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(ALARM_LEN + 1);

    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  BLINK_ON  = CNT_W'(TICK_DIV / 2);
    localparam logic [HOUR_W-1:0] HOUR_TOP  = HOUR_W'(HOUR_MAX);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(ALARM_LEN);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [CNT_W-1:0]  tick_cnt;
    logic [1:0]        mode;
    logic [1:0]        pos;
    logic              tick;
    logic              adv;
    logic              leave_setup;
    logic              edit_time;
    logic              edit_alarm;

    logic [SEC_W-1:0]  sec_q;
    logic [MIN_W-1:0]  min_q;
    logic [HOUR_W-1:0] hour_q;
    logic [MIN_W-1:0]  alarm_min_q;
    logic [HOUR_W-1:0] alarm_hour_q;
    logic              sec_cout;
    logic              min_cout;
    logic              hour_cout;
    logic              unused_am_cout;
    logic              unused_ah_cout;

    logic              day_wrap;
    logic              alarm;
    logic [HOLD_W-1:0] hold;
    logic              match;
    hms_t              next_t;
    hms_t              alarm_t;

    assign tick        = (tick_cnt == TICK_LAST);
    assign leave_setup = (mode == MODE_SETUP) && bus.i_mode_pulse;
    assign adv         = tick && ((mode == MODE_CLOCK) || (mode == MODE_ALARM));
    assign edit_time   = (mode == MODE_SETUP);
    assign edit_alarm  = (mode == MODE_ALARM);

    // Restart the second on leaving SETUP so the first displayed second is whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (leave_setup || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= MODE_CLOCK;
            pos  <= POS_SEC;
        end else begin
            case (mode)
                MODE_CLOCK: begin
                    if (bus.i_mode_pulse) begin
                        mode <= MODE_SETUP;
                        pos  <= POS_SEC;
                    end
                end
                MODE_SETUP: begin
                    if (bus.i_mode_pulse) begin
                        mode <= MODE_ALARM;
                        pos  <= POS_MIN;
                    end else if (bus.i_pos_pulse) begin
                        pos <= (pos == POS_SEC) ? POS_MIN :
                               (pos == POS_MIN) ? POS_HOUR : POS_SEC;
                    end
                end
                MODE_ALARM: begin
                    if (bus.i_mode_pulse) begin
                        mode <= MODE_CLOCK;
                    end else if (bus.i_pos_pulse) begin
                        pos <= (pos == POS_MIN) ? POS_HOUR : POS_MIN;
                    end
                end
                default: begin
                    mode <= MODE_CLOCK;
                    pos  <= POS_SEC;
                end
            endcase
        end
    end

    wrap_cnt #(.WIDTH(SEC_W), .MAX(59)) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (edit_time && (pos == POS_SEC) && bus.i_inc_pulse),
        .dec   (edit_time && (pos == POS_SEC) && bus.i_dec_pulse),
        .cin   (adv),
        .count (sec_q),
        .cout  (sec_cout)
    );

    wrap_cnt #(.WIDTH(MIN_W), .MAX(59)) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (edit_time && (pos == POS_MIN) && bus.i_inc_pulse),
        .dec   (edit_time && (pos == POS_MIN) && bus.i_dec_pulse),
        .cin   (sec_cout),
        .count (min_q),
        .cout  (min_cout)
    );

    wrap_cnt #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (edit_time && (pos == POS_HOUR) && bus.i_inc_pulse),
        .dec   (edit_time && (pos == POS_HOUR) && bus.i_dec_pulse),
        .cin   (min_cout),
        .count (hour_q),
        .cout  (hour_cout)
    );

    wrap_cnt #(.WIDTH(MIN_W), .MAX(59)) u_alarm_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (edit_alarm && (pos == POS_MIN) && bus.i_inc_pulse),
        .dec   (edit_alarm && (pos == POS_MIN) && bus.i_dec_pulse),
        .cin   (1'b0),
        .count (alarm_min_q),
        .cout  (unused_am_cout)
    );

    wrap_cnt #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_alarm_hour (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (edit_alarm && (pos == POS_HOUR) && bus.i_inc_pulse),
        .dec   (edit_alarm && (pos == POS_HOUR) && bus.i_dec_pulse),
        .cin   (1'b0),
        .count (alarm_hour_q),
        .cout  (unused_ah_cout)
    );

    // Time as it will read after this tick, compared against the alarm at :00.
    always_comb begin
        next_t.sec  = (sec_q == SEC_MAX) ? '0 : sec_q + 1'b1;
        next_t.min  = sec_cout ? ((min_q == MIN_MAX) ? '0 : min_q + 1'b1) : min_q;
        next_t.hour = min_cout ? ((hour_q == HOUR_TOP) ? '0 : hour_q + 1'b1) : hour_q;
    end

    assign alarm_t = {alarm_hour_q, alarm_min_q, {SEC_W{1'b0}}};
    assign match   = adv && bus.i_alarm_en && (next_t == alarm_t);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_wrap <= 1'b0;
        end else begin
            day_wrap <= hour_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm <= 1'b0;
            hold  <= '0;
        end else if (bus.i_alarm_clr || !bus.i_alarm_en) begin
            alarm <= 1'b0;
            hold  <= '0;
        end else if (match) begin
            alarm <= 1'b1;
            hold  <= HOLD_INIT;
        end else if (tick && (hold != '0)) begin
            hold <= hold - 1'b1;
            if (hold == HOLD_ONE) begin
                alarm <= 1'b0;
            end
        end
    end

    assign bus.o_sec        = sec_q;
    assign bus.o_min        = min_q;
    assign bus.o_hour       = hour_q;
    assign bus.o_alarm_min  = alarm_min_q;
    assign bus.o_alarm_hour = alarm_hour_q;
    assign bus.o_mode       = mode;
    assign bus.o_position   = pos;
    assign bus.o_blink      = edit_time || edit_alarm ? (tick_cnt < BLINK_ON) : 1'b1;
    assign bus.o_alarm      = alarm;
    assign bus.o_day_wrap   = day_wrap;

endmodule

// File: tb/tb_hms_timekeeper.sv
// tb/tb_hms_timekeeper.sv - vectors, corner sequences and random run against a seconds-of-day model
module tb_hms_timekeeper;

    localparam int TD = 4;
    localparam int AL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode_p = 1'b0, pos_p = 1'b0, inc_p = 1'b0, dec_p = 1'b0, en = 1'b0, clr_p = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hms_if bus_a ();
    hms_if bus_b ();

    assign bus_a.i_mode_pulse = mode_p;
    assign bus_a.i_pos_pulse  = pos_p;
    assign bus_a.i_inc_pulse  = inc_p;
    assign bus_a.i_dec_pulse  = dec_p;
    assign bus_a.i_alarm_en   = en;
    assign bus_a.i_alarm_clr  = clr_p;
    assign bus_b.i_mode_pulse = mode_p;
    assign bus_b.i_pos_pulse  = pos_p;
    assign bus_b.i_inc_pulse  = inc_p;
    assign bus_b.i_dec_pulse  = dec_p;
    assign bus_b.i_alarm_en   = en;
    assign bus_b.i_alarm_clr  = clr_p;

    hms_timekeeper #(.TICK_DIV(TD), .HOUR_MAX(23), .ALARM_LEN(AL)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    hms_timekeeper #(.TICK_DIV(TD), .HOUR_MAX(11), .ALARM_LEN(AL)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Reference: time held as seconds since midnight; fields derived by division.
    int m_cnt, m_mode, m_pos;
    int m_t[2], m_am[2], m_ah[2], m_hold[2];
    bit m_alarm[2], m_wrap[2];

    function automatic int hour_max(input int k);
        return (k == 0) ? 23 : 11;
    endfunction

    function automatic int wrapf(input int v, input int max);
        if (v > max) return 0;
        if (v < 0) return max;
        return v;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_mode = 0; m_pos = 0;
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 0; m_am[k] = 0; m_ah[k] = 0; m_hold[k] = 0;
            m_alarm[k] = 0; m_wrap[k] = 0;
        end
    endtask

    task automatic model_step();
        bit tick, adv, match;
        int ed, nt, h, mi, s, day;
        tick = (m_cnt == TD - 1);
        adv  = tick && (m_mode != 1);
        ed   = (inc_p && !dec_p) ? 1 : (dec_p && !inc_p) ? -1 : 0;
        for (int k = 0; k < 2; k++) begin
            day = (hour_max(k) + 1) * 3600;
            nt = adv ? (m_t[k] + 1) % day : m_t[k];
            m_wrap[k] = adv && (nt == 0);
            match = adv && en && (nt == m_ah[k] * 3600 + m_am[k] * 60);
            h = nt / 3600; mi = (nt / 60) % 60; s = nt % 60;
            if (m_mode == 1 && ed != 0) begin
                if (m_pos == 0) s = wrapf(s + ed, 59);
                else if (m_pos == 1) mi = wrapf(mi + ed, 59);
                else h = wrapf(h + ed, hour_max(k));
            end
            m_t[k] = h * 3600 + mi * 60 + s;
            if (m_mode == 2 && ed != 0) begin
                if (m_pos == 1) m_am[k] = wrapf(m_am[k] + ed, 59);
                else if (m_pos == 2) m_ah[k] = wrapf(m_ah[k] + ed, hour_max(k));
            end
            if (clr_p || !en) begin
                m_alarm[k] = 0; m_hold[k] = 0;
            end else if (match) begin
                m_alarm[k] = 1; m_hold[k] = AL;
            end else if (tick && m_alarm[k]) begin
                m_hold[k]--;
                if (m_hold[k] == 0) m_alarm[k] = 0;
            end
        end
        m_cnt = (m_mode == 1 && mode_p) ? 0 : (m_cnt + 1) % TD;
        if (mode_p) begin
            m_mode = (m_mode + 1) % 3;
            if (m_mode == 1) m_pos = 0;
            else if (m_mode == 2) m_pos = 1;
        end else if (pos_p) begin
            if (m_mode == 1) m_pos = (m_pos + 1) % 3;
            else if (m_mode == 2) m_pos = (m_pos == 1) ? 2 : 1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input int k, input int s, input int mi,
                              input int h, input int am, input int ah, input int al,
                              input int wr, input int md, input int ps, input int bl);
        check({tag, ".sec"}, s, m_t[k] % 60);
        check({tag, ".min"}, mi, (m_t[k] / 60) % 60);
        check({tag, ".hour"}, h, m_t[k] / 3600);
        check({tag, ".alarm_min"}, am, m_am[k]);
        check({tag, ".alarm_hour"}, ah, m_ah[k]);
        check({tag, ".alarm"}, al, int'(m_alarm[k]));
        check({tag, ".day_wrap"}, wr, int'(m_wrap[k]));
        check({tag, ".mode"}, md, m_mode);
        check({tag, ".position"}, ps, m_pos);
        check({tag, ".blink"}, bl, (m_mode == 0) ? 1 : int'(m_cnt < TD / 2));
    endtask

    task automatic check_all();
        check_inst("a", 0, bus_a.o_sec, bus_a.o_min, bus_a.o_hour, bus_a.o_alarm_min,
                   bus_a.o_alarm_hour, bus_a.o_alarm, bus_a.o_day_wrap, bus_a.o_mode,
                   bus_a.o_position, bus_a.o_blink);
        check_inst("b", 1, bus_b.o_sec, bus_b.o_min, bus_b.o_hour, bus_b.o_alarm_min,
                   bus_b.o_alarm_hour, bus_b.o_alarm, bus_b.o_day_wrap, bus_b.o_mode,
                   bus_b.o_position, bus_b.o_blink);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        mode_p = 0; pos_p = 0; inc_p = 0; dec_p = 0; clr_p = 0;
        check_all();
    endtask

    task automatic pulse(input bit m, input bit p, input bit i, input bit d, input bit c);
        mode_p = m; pos_p = p; inc_p = i; dec_p = d; clr_p = c;
        cycle();
    endtask

    function automatic int field_val(input int which);
        case (which)
            0: return m_t[0] % 60;
            1: return (m_t[0] / 60) % 60;
            2: return m_t[0] / 3600;
            3: return m_am[0];
            default: return m_ah[0];
        endcase
    endfunction

    task automatic goto_mode(input int target);
        for (int n = 0; n < 3 && m_mode != target; n++) pulse(1, 0, 0, 0, 0);
    endtask

    task automatic set_field(input int p, input int which, input int target);
        for (int n = 0; n < 4 && m_pos != p; n++) pulse(0, 1, 0, 0, 0);
        for (int n = 0; n < 64 && field_val(which) != target; n++) pulse(0, 0, 1, 0, 0);
    endtask

    task automatic set_time(input int h, input int mi, input int s);
        goto_mode(1);
        set_field(0, 0, s);
        set_field(1, 1, mi);
        set_field(2, 2, h);
    endtask

    task automatic wait_rise(output int rise);
        rise = -1;
        for (int i = 0; i < 60 && rise < 0; i++) begin
            cycle();
            if (bus_a.o_alarm) rise = i;
        end
        check("alarm_rise_seen", int'(rise >= 0), 1);
    endtask

    typedef struct {
        bit m, p, i, d;
        int e_mode, e_pos, e_sec, e_min, e_hour_a, e_hour_b;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int rise, fall, wraps_a, wraps_b, s59_i, wrap_i;

        vecs.push_back('{1, 1, 0, 0, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 1, 0, 59, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 1, 1, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 2, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 1, 2, 0, 0, 23, 11});
        vecs.push_back('{0, 0, 1, 0, 1, 2, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 1, 2, 0, 0, 23, 11});
        vecs.push_back('{0, 0, 1, 1, 1, 2, 0, 0, 23, 11});
        vecs.push_back('{0, 1, 0, 0, 1, 0, 0, 0, 23, 11});

        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1;

        foreach (vecs[n]) begin
            pulse(vecs[n].m, vecs[n].p, vecs[n].i, vecs[n].d, 0);
            check($sformatf("vec%0d.mode", n), bus_a.o_mode, vecs[n].e_mode);
            check($sformatf("vec%0d.pos", n), bus_a.o_position, vecs[n].e_pos);
            check($sformatf("vec%0d.sec", n), bus_a.o_sec, vecs[n].e_sec);
            check($sformatf("vec%0d.min", n), bus_a.o_min, vecs[n].e_min);
            check($sformatf("vec%0d.hour_a", n), bus_a.o_hour, vecs[n].e_hour_a);
            check($sformatf("vec%0d.hour_b", n), bus_b.o_hour, vecs[n].e_hour_b);
        end

        repeat (40) cycle();
        check("frozen_sec", bus_a.o_sec, 0);
        check("frozen_hour", bus_a.o_hour, 23);

        // Preload HOUR_MAX:59:58 and run across midnight.
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 0, 1, 0);
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        pulse(1, 0, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        wraps_a = 0; wraps_b = 0; s59_i = -1; wrap_i = -1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (bus_a.o_sec == 59 && bus_a.o_hour == 23 && s59_i < 0) s59_i = i;
            if (bus_a.o_day_wrap) begin wraps_a++; wrap_i = i; end
            if (bus_b.o_day_wrap) begin
                wraps_b++;
                check("b_wrap_hour", bus_b.o_hour, 0);
            end
        end
        check("wrap_pulses_a", wraps_a, 1);
        check("wrap_pulses_b", wraps_b, 1);
        check("wrap_after_59", wrap_i - s59_i, TD);

        // Alarm at 00:01, full hold length.
        goto_mode(2);
        set_field(1, 3, 1);
        set_field(2, 4, 0);
        en = 1;
        set_time(0, 0, 58);
        goto_mode(0);
        wait_rise(rise);
        check("rise_min", bus_a.o_min, 1);
        check("rise_sec", bus_a.o_sec, 0);
        fall = -1;
        for (int i = 0; i < 40 && fall < 0; i++) begin
            cycle();
            if (!bus_a.o_alarm) fall = i + 1;
        end
        check("alarm_hold_cycles", fall, AL * TD);

        // Clear mid-hold.
        set_time(0, 0, 58);
        goto_mode(0);
        wait_rise(rise);
        cycle();
        cycle();
        pulse(0, 0, 0, 0, 1);
        check("clr_a", bus_a.o_alarm, 0);
        check("clr_b", bus_b.o_alarm, 0);

        // Async reset while editing in ALARM with the alarm sounding.
        set_time(0, 0, 58);
        goto_mode(0);
        wait_rise(rise);
        goto_mode(2);
        check("alarm_before_rst", bus_a.o_alarm, 1);
        inc_p = 1;
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        check("rst_blink", bus_a.o_blink, 1);
        @(negedge clk);
        inc_p = 0;
        rst_n = 1;
        repeat (8) cycle();
        check("resume_sec", bus_a.o_sec, 2);
        check("resume_mode", bus_a.o_mode, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(39) == 0) en = ~en;
            pulse($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(5) == 0,
                  $urandom_range(5) == 0, $urandom_range(29) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/hms_timekeeper.md
Name: hms_timekeeper

Overview:
Parametrised hour:min:sec timekeeping core with an editable alarm. It runs entirely on one system clock; all second advances use a one-cycle tick enable, with no derived or gated clocks. It sits between the debounced, edge-detected button pulses and the digit-split/FND/led_disp display path. It adds hours, a configurable day length, a decrement key, an alarm with an auto-timeout, and a blink phase for the field being edited.

Parameters:
TICK_DIV, 50000000, clk cycles per second; must be at least 2.
HOUR_MAX, 23, last hour value before wrap (23 for a 24 h day, 11 for a 12 h day); must be at most 31.
ALARM_LEN, 60, number of ticks o_alarm stays high unless cleared; must be at least 1.

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  reset
i_mode_pulse  in  1  one-cycle pulse; advances the mode
i_pos_pulse  in  1  one-cycle pulse; advances the edit position
i_inc_pulse  in  1  one-cycle pulse; increments the selected field
i_dec_pulse  in  1  one-cycle pulse; decrements the selected field
i_alarm_en  in  1  level; arms the alarm
i_alarm_clr  in  1  one-cycle pulse; silences the alarm
o_sec  out  6  seconds, 0..59
o_min  out  6  minutes, 0..59
o_hour  out  5  hours, 0..HOUR_MAX
o_alarm_min  out  6  alarm minute
o_alarm_hour  out  5  alarm hour
o_mode  out  2  0 = CLOCK, 1 = SETUP, 2 = ALARM
o_position  out  2  0 = SEC, 1 = MIN, 2 = HOUR
o_blink  out  1  display-enable phase for the selected field
o_alarm  out  1  alarm active
o_day_wrap  out  1  one-cycle pulse on HOUR_MAX:59:59 -> 00:00:00

Behaviour:
Interface: one clock, clk; reset rst_n is asynchronous and active-low. Reset drives every register and output to 0: time 00:00:00, alarm 00:00, mode CLOCK, position SEC, o_alarm = 0, o_day_wrap = 0, tick counter = 0. o_blink therefore comes out of reset at 1.
Reset mid-operation takes effect immediately, regardless of mode or any pulse in flight.

Tick generation:
- tick_cnt counts 0..TICK_DIV-1 and wraps to 0.
- tick is high for one cycle when tick_cnt = TICK_DIV-1.
- tick_cnt is forced to 0 on the cycle the mode leaves SETUP, so the first second after editing is a full second.

Mode FSM (on i_mode_pulse):
- CLOCK -> SETUP -> ALARM -> CLOCK.
- Entering SETUP sets position to SEC.
- Entering ALARM sets position to MIN.
- Code 3 is unreachable; if it is ever decoded, the next cycle goes to CLOCK.
- If i_mode_pulse and i_pos_pulse arrive together, the mode pulse wins and the position pulse is dropped.

Position (on i_pos_pulse):
- SETUP: SEC -> MIN -> HOUR -> SEC.
- ALARM: MIN -> HOUR -> MIN.
- CLOCK: ignored.

Time advance:
- Time advances on tick in CLOCK and ALARM modes only; SETUP freezes time.
- Seconds 59 -> 0 carries into minutes.
- Minutes 59 -> 0 with the carry in carries into hours.
- Hours HOUR_MAX -> 0 with the carry in pulses o_day_wrap in the same cycle the outputs show 00:00:00.
- Output latency: one cycle after tick.

Edit (inc/dec):
- SETUP edits the selected time field; ALARM edits the selected alarm field.
- Each field wraps within its own range: inc at max -> 0, dec at 0 -> max.
- Edits never carry into the neighbouring field.
- Inc and dec in the same cycle: no change.
- In CLOCK mode inc/dec are ignored.
- In ALARM mode, a tick carry and an edit can land on different fields in the same cycle; both take effect.

Alarm:
- match occurs on a tick cycle when i_alarm_en = 1, mode is not SETUP, and the post-increment time equals alarm_hour:alarm_min:00.
- On match, o_alarm is set and a hold counter is loaded with ALARM_LEN.
- The hold counter decrements on each tick; o_alarm drops when it reaches 0.
- i_alarm_clr, or i_alarm_en going low, drops o_alarm the next cycle.
- If i_alarm_clr and a match arrive in the same cycle, clear wins.

Blink:
- CLOCK: o_blink = 1.
- SETUP and ALARM: o_blink = 1 while tick_cnt < TICK_DIV/2, else 0.

Decomposition:
Shared package (hms_pkg) holds:
- Mode encodings MODE_CLOCK, MODE_SETUP, MODE_ALARM.
- Position encodings POS_SEC, POS_MIN, POS_HOUR.
- Constants SEC_MAX = 59 and MIN_MAX = 59.
- Field widths of 6 and 5 bits.

Sub-module wrap_cnt is instanced five times (sec, min, hour, alarm_min, alarm_hour):
- Parameters: WIDTH, MAX.
- Inputs: inc, dec, cin.
- Outputs: count, cout.
- Behaviour: modulo MAX+1, with cin treated as an increment. cout = cin AND (count == MAX).

Test Plan:
1. TICK_DIV = 4, CLOCK mode, preload 23:59:58 via SETUP edits, return to CLOCK -> after 8 cycles the outputs read 00:00:00, o_day_wrap is high for exactly 1 cycle, and 23:59:59 appears 4 cycles earlier.
2. SETUP with time 00:00:59, position SEC, i_inc_pulse -> 00:00:00 with min unchanged; position HOUR, i_dec_pulse at 0 -> hour 23; no advance over 40 cycles.
3. ALARM mode: set alarm 00:01, i_alarm_en = 1, CLOCK from 00:00:58 -> o_alarm rises on the 00:01:00 update; with ALARM_LEN = 3 it falls 3 ticks later; a repeat run with i_alarm_clr mid-hold -> o_alarm falls the next cycle.
4. i_inc_pulse and i_dec_pulse together in SETUP -> field unchanged; i_mode_pulse and i_pos_pulse together in CLOCK -> mode SETUP, position SEC.
5. HOUR_MAX = 11, from 11:59:59 -> next tick 00:00:00 with o_day_wrap; in SETUP, hour inc at 11 -> 0.
6. Assert rst_n low mid-edit in ALARM mode with o_alarm high -> all outputs are 0 and o_blink is 1 asynchronously; after release, counting resumes from 00:00:00 in CLOCK mode.
